// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//
// Upstream operand feeder for a 2-D array of 3-stage MAC PEs. Each accepted
// beat carries one K-step: a column of ROWS activations and a row of COLS
// weights. Every lane is delayed diagonally (row r by 1+r cycles, column c
// by 1+c cycles) so that operands meet at the right PE at the right time.
// The first beat of a tile carries clr so PE accumulators load fresh. After
// the last beat the feeder stops accepting, flushes the skew lines and
// pulses tile_done when the last beat has reached the longest lane.
//
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high. in_valid/in_last/in_x/in_w must stay stable while
// in_valid is high and in_ready is low; in_last is ignored without in_valid.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  beat handshake
//   in_last         beat is the last K-step of the tile
//   in_x            ROWS activation lanes, lane r = [r*IP_size +: IP_size]
//   in_w            COLS weight lanes, lane c = [c*IP_size +: IP_size]
//   x_edge          skewed activations to PE(r,0).x_new
//   w_edge          skewed weights to PE(0,c).w_new
//   en_edge         per-row enable, aligned with x lane r
//   clr_edge        per-row clear, aligned with x lane r
//   busy            high while streaming or flushing a tile
//   tile_done       one-cycle pulse when the tile has fully left the lines
//   state_o         current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int IP_size = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [ROWS*IP_size-1:0] in_x,
  input  logic [COLS*IP_size-1:0] in_w,
  output logic [ROWS*IP_size-1:0] x_edge,
  output logic [COLS*IP_size-1:0] w_edge,
  output logic [ROWS-1:0]         en_edge,
  output logic [ROWS-1:0]         clr_edge,
  output logic                    busy,
  output logic                    tile_done,
  output logic [1:0]              state_o
);

  // Extra skew depth of the longest lane beyond the 1-cycle base latency.
  localparam int D  = ((ROWS > COLS) ? ROWS : COLS) - 1;
  localparam int CW = (D > 0) ? $clog2(D + 1) : 1;
  // The counter holds the number of flush cycles still to go after the
  // current one. tile_done is registered, so it lands on the same cycle the
  // last beat appears on lane D; one flush cycle is the minimum.
  localparam logic [CW-1:0] FLUSH_LOAD = CW'((D > 0) ? D - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            accept;
  logic            inj_en;
  logic            inj_clr;
  logic [ROWS*IP_size-1:0] inj_x;
  logic [COLS*IP_size-1:0] inj_w;

  assign state_o = state_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = FLUSH_LOAD;
          state_d = in_last ? S_FLUSH : S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept && in_last) begin
          cnt_d   = FLUSH_LOAD;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE:   in_ready = ~rst;
      S_STREAM: begin
        in_ready = ~rst;
        busy     = 1'b1;
      end
      S_FLUSH:  busy = 1'b1;
      default:  ;
    endcase
  end

  assign tile_done = done_q;

  // Stage-0 injection: cycles without an accepted beat inject a zero bubble
  // on every lane so gaps stay aligned across the diagonal.
  assign accept  = in_valid & in_ready;
  assign inj_en  = accept;
  assign inj_clr = accept & (state_q == S_IDLE);
  assign inj_x   = accept ? in_x : '0;
  assign inj_w   = accept ? in_w : '0;

  // ---------------- Row lines: x, en, clr (depth 1+r) ----------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [IP_size-1:0] x_l_q   [0:r];
    logic               en_l_q  [0:r];
    logic               clr_l_q [0:r];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= r; s++) begin
          x_l_q[s]   <= '0;
          en_l_q[s]  <= 1'b0;
          clr_l_q[s] <= 1'b0;
        end
      end else begin
        x_l_q[0]   <= inj_x[r*IP_size +: IP_size];
        en_l_q[0]  <= inj_en;
        clr_l_q[0] <= inj_clr;
        for (int s = 1; s <= r; s++) begin
          x_l_q[s]   <= x_l_q[s-1];
          en_l_q[s]  <= en_l_q[s-1];
          clr_l_q[s] <= clr_l_q[s-1];
        end
      end
    end

    assign x_edge[r*IP_size +: IP_size] = x_l_q[r];
    assign en_edge[r]                   = en_l_q[r];
    assign clr_edge[r]                  = clr_l_q[r];
  end

  // ---------------- Column lines: w (depth 1+c) ----------------
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [IP_size-1:0] w_l_q [0:c];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= c; s++) begin
          w_l_q[s] <= '0;
        end
      end else begin
        w_l_q[0] <= inj_w[c*IP_size +: IP_size];
        for (int s = 1; s <= c; s++) begin
          w_l_q[s] <= w_l_q[s-1];
        end
      end
    end

    assign w_edge[c*IP_size +: IP_size] = w_l_q[c];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Directed bench for systolic_skew_feeder with ROWS=COLS=4, IP_size=8.
// Every cycle the bench pushes the slot it expects to enter stage 0 (beat
// data when it expects acceptance, zeros otherwise) onto exp_q. After the
// clock edge, lane r is compared against the slot pushed r edges earlier,
// which is the 1+r cycle skew of that lane.
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int IP   = 8;
  localparam int XW   = ROWS * IP;
  localparam int WW   = COLS * IP;
  localparam int SW   = 2 * ROWS + XW + WW;
  localparam int CMPW = 72;

  typedef struct packed {
    logic [ROWS-1:0] en;
    logic [ROWS-1:0] clr;
    logic [XW-1:0]   x;
    logic [WW-1:0]   w;
  } slot_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last  = 1'b0;
  logic [XW-1:0]   in_x     = '0;
  logic [WW-1:0]   in_w     = '0;
  logic [XW-1:0]   x_edge;
  logic [WW-1:0]   w_edge;
  logic [ROWS-1:0] en_edge;
  logic [ROWS-1:0] clr_edge;
  logic            busy;
  logic            tile_done;
  logic [1:0]      state_o;

  systolic_skew_feeder #(.ROWS(ROWS), .COLS(COLS), .IP_size(IP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_x      (in_x),
    .in_w      (in_w),
    .x_edge    (x_edge),
    .w_edge    (w_edge),
    .en_edge   (en_edge),
    .clr_edge  (clr_edge),
    .busy      (busy),
    .tile_done (tile_done),
    .state_o   (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  task automatic chk(input string tag, input logic [CMPW-1:0] obs,
                     input logic [CMPW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back('0);
  endtask

  task automatic check_lanes();
    slot_t s;
    logic [XW-1:0]   ex;
    logic [WW-1:0]   ew;
    logic [ROWS-1:0] een;
    logic [ROWS-1:0] eclr;
    for (int r = 0; r < ROWS; r++) begin
      s = slot_t'(exp_q[exp_q.size() - 1 - r]);
      ex[r*IP +: IP] = s.x[r*IP +: IP];
      een[r]         = s.en[r];
      eclr[r]        = s.clr[r];
    end
    for (int c = 0; c < COLS; c++) begin
      s = slot_t'(exp_q[exp_q.size() - 1 - c]);
      ew[c*IP +: IP] = s.w[c*IP +: IP];
    end
    chk("x_edge",   CMPW'(x_edge),   CMPW'(ex));
    chk("w_edge",   CMPW'(w_edge),   CMPW'(ew));
    chk("en_edge",  CMPW'(en_edge),  CMPW'(een));
    chk("clr_edge", CMPW'(clr_edge), CMPW'(eclr));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge. e_rdy/e_busy are expected before the
  // rising edge, e_done is expected right after it.
  task automatic step(input logic v, input logic l, input logic [XW-1:0] xv,
                      input logic [WW-1:0] wv, input logic e_rdy,
                      input logic e_busy, input logic e_clr,
                      input logic e_done);
    slot_t s;
    logic  acc;
    in_valid = v;
    in_last  = l;
    in_x     = xv;
    in_w     = wv;
    #1;
    chk("in_ready", CMPW'(in_ready), CMPW'(e_rdy));
    chk("busy",     CMPW'(busy),     CMPW'(e_busy));
    acc   = v & e_rdy;
    s.en  = {ROWS{acc}};
    s.clr = {ROWS{acc & e_clr}};
    s.x   = acc ? xv : '0;
    s.w   = acc ? wv : '0;
    @(posedge clk);
    exp_q.push_back(SW'(s));
    if (exp_q.size() > 8) void'(exp_q.pop_front());
    @(negedge clk);
    check_lanes();
    chk("tile_done", CMPW'(tile_done), CMPW'(e_done));
    if (tile_done) done_seen++;
  endtask

  task automatic idle(input logic e_rdy, input logic e_busy,
                      input logic e_done);
    step(1'b0, 1'b0, '0, '0, e_rdy, e_busy, 1'b0, e_done);
  endtask

  function automatic logic [XW-1:0] xk(input int k);
    logic [XW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*IP +: IP] = IP'((r + 1) * k);
    return v;
  endfunction

  function automatic logic [WW-1:0] wk(input int k);
    logic [WW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*IP +: IP] = IP'((c + 1) * 10 * k);
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [XW-1:0] sx;
    logic [WW-1:0] sw;

    // Power-on reset.
    @(negedge clk);
    @(negedge clk);
    chk("rst_x_edge", CMPW'(x_edge), '0);
    chk("rst_busy",   CMPW'(busy),   '0);
    rst = 1'b0;
    sb_reset();
    idle(1'b1, 1'b0, 1'b0);

    // Reset mid-STREAM after two beats: outputs clear before the next edge.
    step(1'b1, 1'b0, xk(1), wk(1), 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, xk(2), wk(2), 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_x_edge",   CMPW'(x_edge),    '0);
    chk("arst_w_edge",   CMPW'(w_edge),    '0);
    chk("arst_en_edge",  CMPW'(en_edge),   '0);
    chk("arst_clr_edge", CMPW'(clr_edge),  '0);
    chk("arst_busy",     CMPW'(busy),      '0);
    chk("arst_done",     CMPW'(tile_done), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_reset();
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b0, 1'b0);
    chk("arst_no_done", CMPW'(done_seen), '0);

    // Single tile, K=3, continuous beats; flush takes three cycles.
    for (int k = 1; k <= 3; k++)
      step(1'b1, (k == 3), xk(k), wk(k), 1'b1, (k != 1), (k == 1), 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b0);

    // Bubble between beats 1 and 2.
    step(1'b1, 1'b0, xk(1), wk(1), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, xk(2), wk(2), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, xk(3), wk(3), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b0);

    // Single-beat tile: en and clr share a slot, IDLE goes straight to FLUSH.
    step(1'b1, 1'b1, xk(5), wk(5), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b0);

    // Back-to-back tiles with in_valid held through FLUSH.
    step(1'b1, 1'b1, xk(2), wk(2), 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, xk(4), wk(4), 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, xk(4), wk(4), 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, xk(4), wk(4), 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, xk(4), wk(4), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b0);

    // Signed passthrough on lane 3: -128 and 127 arrive unmodified.
    sx = {8'h80, 8'h03, 8'h02, 8'h01};
    sw = {8'h7F, 8'hF0, 8'h81, 8'hFF};
    step(1'b1, 1'b1, sx, sw, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    chk("x_lane3_signed", CMPW'(x_edge[3*IP +: IP]), CMPW'(8'h80));
    chk("w_lane3_signed", CMPW'(w_edge[3*IP +: IP]), CMPW'(8'h7F));
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
